crc_serial_framer: RTL and testbench
====================================

# crc_serial_framer

Parametrised serial CRC framer for tracker-board output streams. It passes a bit-serial packet through with one clock of latency, then appends a W-bit CRC (MSB first) and NTRAIL trailer 1-bits. A check mode instead verifies a stream that already carries its CRC. It sits between the event serialiser and the link driver, and in loop-back test firmware on the receive side.

## Interface
Parameters:
- W, 6: CRC width, 2..16.
- POLY, 6'b100101: generator polynomial low W bits; the x^W term is implicit.
- INIT, 0: CRC register value at reset and at the start of each packet.
- NTRAIL, 2: number of 1-bits appended after the CRC, 0..15.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- Din  in  1  serial data bit.
- Valid  in  1  Din carries a packet bit this cycle.
- Stop  in  1  qualifies the last packet bit; it is meaningful only with Valid.
- Mode  in  1  0 = generate/append, 1 = check; held static for a whole packet.
- Dout  out  1  serial output stream (registered).
- Dval  out  1  Dout carries a stream bit this cycle (registered).
- Busy  out  1  high while appending; upstream must hold Valid low.
- Done  out  1  one-cycle end-of-packet pulse (registered).
- CrcErr  out  1  check-mode result, valid with Done; holds until the next Done.

## Operation
- CRC step per accepted bit: fb = crc[W-1]^Din; crc <= {crc[W-2:0],0} ^ (fb ? POLY : 0). This is a non-reflected form with no final XOR.
- States: DATA, CRC, TRAIL.
- DATA, Valid=1:
  - crc is stepped.
  - Dout<=Din, Dval<=1.
- DATA, Valid=1 and Stop=1 with Mode=0:
  - Go to CRC, cnt<=0.
  - This step's result is the value that gets shifted out.
- DATA, Valid=1 and Stop=1 with Mode=1:
  - Stay in DATA.
  - Done<=1; CrcErr<=(stepped crc != 0); crc<=INIT.
- DATA, Valid=0: Dout<=0, Dval<=0; crc unchanged.
- CRC state, each cycle:
  - Dout<=crc[W-1], Dval<=1, crc<=crc<<1, cnt++.
  - At cnt==W-1: go to TRAIL with cnt<=0; if NTRAIL==0, go to DATA instead with Done<=1 and crc<=INIT.
- TRAIL state, each cycle:
  - Dout<=1, Dval<=1, cnt++.
  - At cnt==NTRAIL-1: Done<=1, crc<=INIT, go to DATA.
- Busy = (state != DATA).
- Valid and Stop are ignored while Busy; such bits are dropped and never enter the CRC.
- Stop without Valid is ignored.
- Done is 0 in every cycle not listed above.
- Reset, at any point including mid-packet or mid-append:
  - state DATA, crc INIT, cnt 0.
  - Dout, Dval, Done, CrcErr all 0.
  - Busy 0 in the following cycle; no Done is produced for the aborted packet.
- Leading zero bits with INIT=0 do not alter the CRC; this is intended.

## Timing
- Pass-through latency is 1 clock: a Din bit accepted at edge k appears on Dout after edge k.
- Last data bit (Stop) accepted at edge n, generate mode:
  - last data bit on Dout after edge n.
  - CRC bits after edges n+1..n+W.
  - trailer bits after edges n+W+1..n+W+NTRAIL.
  - Done high coincident with the last appended bit.
- Busy rises after edge n and falls after the edge that asserts Done.
- Valid may be accepted in the same cycle Done is high, giving back-to-back packets with no gap.
- Check mode: Done and CrcErr assert after edge n, alongside the last data bit on Dout; no bits are appended and Busy never rises.

## Structure
- Shared package crc_pkg holds:
  - the state enum (DATA, CRC, TRAIL);
  - the function crc_step(crc, din, poly), width-generic via a parameter;
  - the constant CRC6_TRK_POLY = 6'b100101.
- Counter width is $clog2(max(W,NTRAIL,2)).
- No sub-module: a single always_ff plus the package function.

## Test plan
- Generate, defaults: packet 1,0 with Stop on the second bit → Dout stream 1,0,1,0,1,1,1,1,1,1; Done with the final 1.
- Generate, single bit 1 → CRC 100101, then 1,1; Busy high for exactly 8 cycles.
- Check mode: stream 1,0,1,0,1,1,1,1 with Stop on the last bit → Done, CrcErr=0. Flip bit 3 → CrcErr=1.
- W=8, POLY=8'h07, NTRAIL=0: byte 8'h01 → CRC 8'h07 appended, Done on the last CRC bit, no trailer.
- Reset asserted mid-CRC shift → outputs 0 the next cycle, no Done. A following 1,0 packet yields the correct 101111.
- Valid pulsed while Busy → ignored. Back-to-back packets with Valid during the Done cycle → both CRCs are correct.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types, constants and the CRC step function for the serial CRC framer.
// The step function works on a fixed 16-bit container so one definition serves every width.
package crc_pkg;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        CRC   = 2'd1,
        TRAIL = 2'd2
    } state_t;

    localparam int CRC_MAXW = 16;
    localparam logic [5:0] CRC6_TRK_POLY = 6'b100101;

    // Non-reflected, one-bit LFSR step; only the low w bits of the result are meaningful.
    function automatic logic [CRC_MAXW-1:0] crc_step(
        input logic [CRC_MAXW-1:0] crc,
        input logic                din,
        input logic [CRC_MAXW-1:0] poly,
        input logic [4:0]          w
    );
        logic [CRC_MAXW-1:0] mask;
        logic                fb;
        mask = (CRC_MAXW'(1) << w) - CRC_MAXW'(1);
        fb   = crc[4'(w - 5'd1)] ^ din;
        return ((crc << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/crc_serial_framer.sv
// Bit-serial CRC framer: passes a packet through with one clock of latency, then appends
// the CRC (MSB first) and NTRAIL 1-bits; in check mode it flags a non-zero residue instead.
//
//   state | meaning
//   DATA  | pass-through of packet bits, idle when Valid is low
//   CRC   | shifting the CRC register out MSB first
//   TRAIL | emitting the trailer 1-bits
module crc_serial_framer
    import crc_pkg::*;
#(
    parameter int           W      = 6,
    parameter logic [W-1:0] POLY   = W'(CRC6_TRK_POLY),
    parameter logic [W-1:0] INIT   = '0,
    parameter int           NTRAIL = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Din,
    input  logic Valid,
    input  logic Stop,
    input  logic Mode,
    output logic Dout,
    output logic Dval,
    output logic Busy,
    output logic Done,
    output logic CrcErr
);

    localparam int CMAX = (W > NTRAIL) ? ((W > 2) ? W : 2) : ((NTRAIL > 2) ? NTRAIL : 2);
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] CNT_CRC_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] CNT_TRAIL_LAST = (NTRAIL > 0) ? CW'(NTRAIL - 1) : '0;

    state_t              state;
    logic [W-1:0]        crc;
    logic [CW-1:0]       cnt;
    logic [CRC_MAXW-1:0] step_full;
    logic [W-1:0]        crc_next;

    assign step_full = crc_step(CRC_MAXW'(crc), Din, CRC_MAXW'(POLY), 5'(W));
    assign crc_next  = step_full[W-1:0];
    assign Busy      = (state != DATA);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= DATA;
            crc    <= INIT;
            cnt    <= '0;
            Dout   <= 1'b0;
            Dval   <= 1'b0;
            Done   <= 1'b0;
            CrcErr <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                DATA: begin
                    if (Valid) begin
                        Dout <= Din;
                        Dval <= 1'b1;
                        crc  <= crc_next;
                        if (Stop) begin
                            if (Mode) begin
                                Done   <= 1'b1;
                                CrcErr <= (crc_next != '0);
                                crc    <= INIT;
                            end else begin
                                state <= CRC;
                                cnt   <= '0;
                            end
                        end
                    end else begin
                        Dout <= 1'b0;
                        Dval <= 1'b0;
                    end
                end
                CRC: begin
                    Dout <= crc[W-1];
                    Dval <= 1'b1;
                    crc  <= crc << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_CRC_LAST) begin
                        cnt <= '0;
                        if (NTRAIL == 0) begin
                            state  <= DATA;
                            Done   <= 1'b1;
                            CrcErr <= 1'b0;
                            crc    <= INIT;
                        end else begin
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    Dout <= 1'b1;
                    Dval <= 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_TRAIL_LAST) begin
                        cnt    <= '0;
                        state  <= DATA;
                        Done   <= 1'b1;
                        CrcErr <= 1'b0;
                        crc    <= INIT;
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_framer.sv
// Self-checking bench for crc_serial_framer: default 6-bit instance plus an 8-bit, no-trailer
// instance, checked against a polynomial long-division reference model.
module tb_crc_serial_framer;

    typedef bit bitq_t[$];

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Din = 1'b0, Valid = 1'b0, Stop = 1'b0, Mode = 1'b0, valid8 = 1'b0;
    logic Dout, Dval, Busy, Done, CrcErr;
    logic dout8, dval8, busy8, done8, crcerr8;

    int errors = 0;
    int checks = 0;

    bitq_t oq, oq8;
    int    done_idx[$], done8_idx[$];
    int    done_cnt = 0, done8_cnt = 0, busy_cycles = 0;
    bit    last_err = 1'b0;

    always #5 Clock = ~Clock;

    crc_serial_framer u_dut (
        .Clock(Clock), .Reset(Reset), .Din(Din), .Valid(Valid), .Stop(Stop), .Mode(Mode),
        .Dout(Dout), .Dval(Dval), .Busy(Busy), .Done(Done), .CrcErr(CrcErr)
    );

    crc_serial_framer #(.W(8), .POLY(8'h07), .INIT(8'h00), .NTRAIL(0)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .Din(Din), .Valid(valid8), .Stop(Stop), .Mode(Mode),
        .Dout(dout8), .Dval(dval8), .Busy(busy8), .Done(done8), .CrcErr(crcerr8)
    );

    always @(negedge Clock) begin
        if (Dval) oq.push_back(Dout);
        if (Done) begin
            done_cnt++;
            done_idx.push_back(oq.size());
            last_err = CrcErr;
        end
        if (Busy) busy_cycles++;
        if (dval8) oq8.push_back(dout8);
        if (done8) begin
            done8_cnt++;
            done8_idx.push_back(oq8.size());
        end
    end

    // Remainder of msg(x) * x^w divided by gen(x), gen including its x^w term.
    function automatic int ref_crc(input bitq_t msg, input int w, input int gen);
        int rem = 0;
        for (int i = 0; i < msg.size() + w; i++) begin
            rem = (rem << 1) | ((i < msg.size()) ? int'(msg[i]) : 0);
            if ((rem >> w) & 1) rem = rem ^ gen;
        end
        return rem;
    endfunction

    function automatic bitq_t build_gen(input bitq_t msg, input int w, input int gen, input int ntrail);
        bitq_t q = msg;
        int r = ref_crc(msg, w, gen);
        for (int i = w - 1; i >= 0; i--) q.push_back(bit'((r >> i) & 1));
        for (int i = 0; i < ntrail; i++) q.push_back(1'b1);
        return q;
    endfunction

    function automatic bitq_t rand_msg(input int len);
        bitq_t q;
        for (int i = 0; i < len; i++) q.push_back(bit'($urandom_range(0, 1)));
        return q;
    endfunction

    function automatic bit same_q(input bitq_t a, input bitq_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mon();
        oq.delete(); oq8.delete(); done_idx.delete(); done8_idx.delete();
        done_cnt = 0; done8_cnt = 0; busy_cycles = 0;
    endtask

    // Called away from the rising edge; leaves the bench 1 time unit after a rising edge.
    task automatic drive_bits(input bitq_t msg, input bit mode, input bit sel, input bit hold);
        for (int i = 0; i < msg.size(); i++) begin
            Din = msg[i]; Mode = mode; Stop = (i == msg.size() - 1);
            if (sel) valid8 = 1'b1; else Valid = 1'b1;
            @(posedge Clock); #1;
        end
        if (!hold) begin
            Valid = 1'b0; valid8 = 1'b0; Stop = 1'b0; Din = 1'b0;
        end
    endtask

    task automatic wait_done(input int target, input bit sel, input string name);
        for (int i = 0; i < 60; i++) begin
            if ((sel ? done8_cnt : done_cnt) >= target) break;
            @(posedge Clock); #1;
        end
        checks++;
        if ((sel ? done8_cnt : done_cnt) < target) begin
            errors++;
            $display("FAIL %s timeout: done count %0d, required %0d", name, sel ? done8_cnt : done_cnt, target);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Valid = 1'b1; Din = 1'b1; Stop = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Valid = 1'b0; Din = 1'b0; Stop = 1'b0;
        checks++; if (Dout !== 1'b0)   begin errors++; $display("FAIL reset_dout got %b want 0", Dout); end
        checks++; if (Dval !== 1'b0)   begin errors++; $display("FAIL reset_dval got %b want 0", Dval); end
        checks++; if (Busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (CrcErr !== 1'b0) begin errors++; $display("FAIL reset_crcerr got %b want 0", CrcErr); end
        Reset = 1'b0;
        @(posedge Clock); #1;
        clear_mon();
    endtask

    task automatic test_gen_fixed();
        bitq_t exp_a = '{1,0,1,0,1,1,1,1,1,1};
        bitq_t exp_b = '{1,1,0,0,1,0,1,1,1};
        clear_mon();
        drive_bits('{1,0}, 1'b0, 1'b0, 1'b0);
        wait_done(1, 1'b0, "gen_10");
        checks++;
        if (!same_q(oq, exp_a)) begin errors++; $display("FAIL gen_10_stream got %p want %p", oq, exp_a); end
        checks++;
        if (done_idx.size() != 1 || done_idx[0] != 10) begin
            errors++; $display("FAIL gen_10_done_pos got %p want 10", done_idx);
        end
        repeat (2) @(posedge Clock); #1;
        clear_mon();
        drive_bits('{1}, 1'b0, 1'b0, 1'b0);
        wait_done(1, 1'b0, "gen_1");
        checks++;
        if (!same_q(oq, exp_b)) begin errors++; $display("FAIL gen_1_stream got %p want %p", oq, exp_b); end
        checks++;
        if (busy_cycles != 8) begin errors++; $display("FAIL gen_1_busy got %0d want 8", busy_cycles); end
        repeat (2) @(posedge Clock); #1;
    endtask

    task automatic test_gen_random();
        for (int p = 0; p < 6; p++) begin
            bitq_t msg = rand_msg($urandom_range(1, 16));
            bitq_t exp = build_gen(msg, 6, 'h65, 2);
            clear_mon();
            drive_bits(msg, 1'b0, 1'b0, 1'b0);
            wait_done(1, 1'b0, "gen_rand");
            checks++;
            if (!same_q(oq, exp)) begin errors++; $display("FAIL gen_rand_stream got %p want %p", oq, exp); end
            checks++;
            if (done_idx.size() != 1 || done_idx[0] != exp.size() || busy_cycles != 8) begin
                errors++;
                $display("FAIL gen_rand_done got idx %p busy %0d want idx %0d busy 8", done_idx, busy_cycles, exp.size());
            end
            repeat ($urandom_range(0, 3)) @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_check();
        bitq_t good = '{1,0,1,0,1,1,1,1};
        bitq_t bad  = '{1,0,1,1,1,1,1,1};
        clear_mon();
        drive_bits(good, 1'b1, 1'b0, 1'b0);
        wait_done(1, 1'b0, "check_good");
        checks++;
        if (last_err !== 1'b0 || done_idx.size() != 1 || done_idx[0] != 8) begin
            errors++; $display("FAIL check_good got err %b idx %p want err 0 idx 8", last_err, done_idx);
        end
        checks++;
        if (!same_q(oq, good) || busy_cycles != 0) begin
            errors++; $display("FAIL check_passthru got %p busy %0d want %p busy 0", oq, busy_cycles, good);
        end
        clear_mon();
        drive_bits(bad, 1'b1, 1'b0, 1'b0);
        wait_done(1, 1'b0, "check_bad");
        checks++;
        if (last_err !== 1'b1) begin errors++; $display("FAIL check_bad got err %b want 1", last_err); end
        for (int p = 0; p < 4; p++) begin
            bitq_t msg = build_gen(rand_msg($urandom_range(1, 12)), 6, 'h65, 0);
            int flip = $urandom_range(0, msg.size() - 1);
            clear_mon();
            drive_bits(msg, 1'b1, 1'b0, 1'b0);
            wait_done(1, 1'b0, "check_rand_good");
            checks++;
            if (last_err !== 1'b0) begin errors++; $display("FAIL check_rand_good got err %b want 0", last_err); end
            msg[flip] = ~msg[flip];
            clear_mon();
            drive_bits(msg, 1'b1, 1'b0, 1'b0);
            wait_done(1, 1'b0, "check_rand_bad");
            checks++;
            if (last_err !== 1'b1) begin errors++; $display("FAIL check_rand_bad got err %b want 1 (flip %0d)", last_err, flip); end
        end
        Mode = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_w8();
        bitq_t msg = '{0,0,0,0,0,0,0,1};
        bitq_t exp = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,1,1,1};
        bitq_t rmsg = rand_msg(8);
        bitq_t rexp = build_gen(rmsg, 8, 'h107, 0);
        clear_mon();
        drive_bits(msg, 1'b0, 1'b1, 1'b0);
        wait_done(1, 1'b1, "w8_01");
        checks++;
        if (!same_q(oq8, exp)) begin errors++; $display("FAIL w8_01_stream got %p want %p", oq8, exp); end
        checks++;
        if (done8_idx.size() != 1 || done8_idx[0] != 16) begin
            errors++; $display("FAIL w8_done_pos got %p want 16", done8_idx);
        end
        repeat (2) @(posedge Clock); #1;
        clear_mon();
        drive_bits(rmsg, 1'b0, 1'b1, 1'b0);
        wait_done(1, 1'b1, "w8_rand");
        checks++;
        if (!same_q(oq8, rexp)) begin errors++; $display("FAIL w8_rand_stream got %p want %p", oq8, rexp); end
        repeat (2) @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid();
        bitq_t exp = '{1,0,1,0,1,1,1,1,1,1};
        clear_mon();
        drive_bits('{1,1}, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        checks++;
        if ({Dout, Dval, Done, CrcErr, Busy} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_outputs got %b want 00000", {Dout, Dval, Done, CrcErr, Busy});
        end
        Reset = 1'b0;
        repeat (15) @(posedge Clock);
        #1;
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_nodone got %0d want 0", done_cnt); end
        clear_mon();
        drive_bits('{1,0}, 1'b0, 1'b0, 1'b0);
        wait_done(1, 1'b0, "reset_mid_after");
        checks++;
        if (!same_q(oq, exp)) begin errors++; $display("FAIL reset_mid_after got %p want %p", oq, exp); end
        repeat (2) @(posedge Clock); #1;
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            bitq_t a = rand_msg($urandom_range(1, 8));
            bitq_t b = rand_msg($urandom_range(1, 8));
            bitq_t exp = build_gen(a, 6, 'h65, 2);
            bitq_t expb = build_gen(b, 6, 'h65, 2);
            int first_len = exp.size();
            bit seen = 1'b0;
            foreach (expb[i]) exp.push_back(expb[i]);
            clear_mon();
            drive_bits(a, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 40; i++) begin
                if (Done) begin seen = 1'b1; break; end
                Valid = 1'b1; Din = bit'($urandom_range(0, 1)); Stop = bit'($urandom_range(0, 1));
                @(posedge Clock); #1;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL b2b_first_done timeout got none want 1"); end
            drive_bits(b, 1'b0, 1'b0, 1'b0);
            wait_done(2, 1'b0, "b2b_second");
            checks++;
            if (!same_q(oq, exp)) begin errors++; $display("FAIL b2b_stream got %p want %p", oq, exp); end
            checks++;
            if (done_idx.size() != 2 || done_idx[0] != first_len || done_idx[1] != exp.size() || busy_cycles != 16) begin
                errors++;
                $display("FAIL b2b_done got idx %p busy %0d want idx %0d,%0d busy 16", done_idx, busy_cycles, first_len, exp.size());
            end
            repeat (2) @(posedge Clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_gen_fixed();
        test_gen_random();
        test_check();
        test_w8();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
